rr_mux_sel_arbiter: RTL and testbench

//   Round-robin arbiter that drives the select of the downstream 4:1 mux (sel[1:0]).
//   - N_CH requesters compete for the shared mux path.
//   - The winner's index goes out on sel, with a one-hot grant.
//   - The grant is held until the requester releases it or a hold timeout expires.
//   - Sits directly upstream of mux4to1: sel -> mux.sel.

---
 rtl/rr_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_mux_sel_arbiter.sv | 147 ++++++++++++++
 tb/tb_rr_mux_sel_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and default parameters for the round-robin mux-select arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} rr_state_t;

  localparam int N_CH_DEF     = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W_DEF    = 16;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request scanning ptr, ptr+1, ... mod N_CH.
// N_CH must be a power of two so the index wraps by plain truncation.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from ptr upward; the first hit wins and later candidates are ignored.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = ptr + SEL_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of the downstream 4:1 mux.
// Optional per-channel grant statistics are enabled with RR_ARB_STATS_EN.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no owner; grant/busy low, sel keeps the last owner's index
//  GRANT | one channel owns the mux path until release or hold timeout
module rr_mux_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SEL_W    = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             busy
`ifdef RR_ARB_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);

  // A width of at least one keeps MAX_HOLD=1 legal; the compare is then always true.
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  rr_state_t        state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic             release_c;
  logic             new_grant;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  // In GRANT the encoder already scans from the post-release pointer, so the
  // released owner competes at lowest priority on the same edge.
  assign pick_ptr  = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
  assign release_c = ~req[sel_q] | done | (hold_q == HOLD_W'(MAX_HOLD - 1));

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d          = GRANT;
          sel_d            = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d           = 1'b1;
          hold_d           = '0;
          new_grant        = 1'b1;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d  = sel_q + SEL_W'(1);
          hold_d = '0;
          if (pick_any) begin
            sel_d             = pick_idx;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            new_grant         = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

`ifdef RR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  // Saturating per-channel count of new grants, including back-to-back re-grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else if (new_grant && (cnt_q[pick_idx] != {CNT_W{1'b1}})) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule : rr_mux_sel_arbiter

// File: tb/tb_rr_mux_sel_arbiter.sv
// Directed bench for rr_mux_sel_arbiter: instance A uses defaults (MAX_HOLD=8),
// instance B uses MAX_HOLD=1, CNT_W=4 for per-cycle rotation and saturation.
module tb_rr_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic       done_a, done_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b;
`ifdef RR_ARB_STATS_EN
  logic [63:0] gcnt_a;
  logic [15:0] gcnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_mux_sel_arbiter u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_a),
    .done  (done_a),
    .sel   (sel_a),
    .grant (grant_a),
    .busy  (busy_a)
`ifdef RR_ARB_STATS_EN
    ,
    .grant_cnt (gcnt_a)
`endif
  );

  rr_mux_sel_arbiter #(.N_CH(4), .MAX_HOLD(1), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_b),
    .done  (done_b),
    .sel   (sel_b),
    .grant (grant_b),
    .busy  (busy_b)
`ifdef RR_ARB_STATS_EN
    ,
    .grant_cnt (gcnt_b)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int s, input logic [3:0] g, input logic b);
    check_vec({tag, ".sel"},   32'(sel_a),   32'(s));
    check_vec({tag, ".grant"}, 32'(grant_a), 32'(g));
    check_vec({tag, ".busy"},  32'(busy_a),  32'(b));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Expected sel for 1111 with done on every 2nd cycle from tick 3 onward.
  int rot_sel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int rot_b   [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n  = 1'b0;
    req_a  = 4'b1111;
    req_b  = 4'b0000;
    done_a = 1'b0;
    done_b = 1'b0;
    #2;

    // Reset held two clocks with all requests asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_a("rst", 0, 4'b0000, 1'b0);
    end
    req_a = 4'b0000;
    rst_n = 1'b1;
    tick();

    // Single requester: one-cycle latency, then release leaves sel in place.
    req_a = 4'b0100;
    tick();
    chk_a("single", 2, 4'b0100, 1'b1);
    tick();
    chk_a("single_hold", 2, 4'b0100, 1'b1);
    req_a = 4'b0000;
    tick();
    chk_a("single_rel", 2, 4'b0000, 1'b0);

    // Full request with done every other cycle: rotation with no idle gaps.
    pulse_reset();
    req_a = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      done_a = (i >= 2) && (i % 2 == 0);
      tick();
      chk_a($sformatf("rot%0d", i), rot_sel[i], 4'b0001 << rot_sel[i], 1'b1);
    end
    done_a = 1'b0;
    req_a  = 4'b0000;
    tick();
    check_vec("rot_end.busy", 32'(busy_a), 32'd0);

    // Hold timeout: ch0 8 clocks, ch1 8 clocks, then back to ch0.
    pulse_reset();
    req_a = 4'b0011;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk_a($sformatf("hold%0d", i), (i >= 8 && i < 16) ? 1 : 0,
            (i >= 8 && i < 16) ? 4'b0010 : 4'b0001, 1'b1);
    end
    req_a = 4'b0000;
    tick();

    // Reset during a ch1 grant, then pointer restarts at 0.
    pulse_reset();
    req_a = 4'b0010;
    tick();
    chk_a("pre_rst", 1, 4'b0010, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_a("mid_rst", 0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    req_a = 4'b0110;
    tick();
    chk_a("post_rst", 1, 4'b0010, 1'b1);
    done_a = 1'b1;
    tick();
    chk_a("post_rst_rot", 2, 4'b0100, 1'b1);
    done_a = 1'b0;
    req_a  = 4'b0000;
    tick();

    // Non-owner request arriving mid-grant waits for release (ptr is 3 here).
    req_a = 4'b0001;
    tick();
    chk_a("nonown0", 0, 4'b0001, 1'b1);
    req_a = 4'b1001;
    tick();
    chk_a("nonown1", 0, 4'b0001, 1'b1);
    tick();
    chk_a("nonown2", 0, 4'b0001, 1'b1);
    done_a = 1'b1;
    tick();
    chk_a("nonown_rel", 3, 4'b1000, 1'b1);
    done_a = 1'b0;
    req_a  = 4'b0000;
    tick();
    chk_a("nonown_idle", 3, 4'b0000, 1'b0);

    // Timeout with only the owner requesting re-grants it without a gap.
    req_a = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a($sformatf("regrant%0d", i), 2, 4'b0100, 1'b1);
    end
    req_a = 4'b0000;
    tick();

    // MAX_HOLD=1: rotation every clock.
    pulse_reset();
`ifdef RR_ARB_STATS_EN
    check_vec("b_cnt_rst", 32'(gcnt_b), 32'h0);
`endif
    req_b = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("b_rot%0d.sel", i), 32'(sel_b), 32'(rot_b[i]));
      check_vec($sformatf("b_rot%0d.grant", i), 32'(grant_b), 32'(4'b0001 << rot_b[i]));
    end
`ifdef RR_ARB_STATS_EN
    check_vec("b_cnt_rot", 32'(gcnt_b), 32'h1112);
`endif
    req_b = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_vec($sformatf("b_solo%0d.grant", i), 32'(grant_b), 32'h1);
    end
`ifdef RR_ARB_STATS_EN
    check_vec("b_cnt_sat", 32'(gcnt_b[3:0]), 32'd15);
    check_vec("b_cnt_other", 32'(gcnt_b[15:4]), 32'h111);
`endif
    req_b = 4'b0000;
    tick();
    check_vec("b_idle.busy", 32'(busy_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rr_mux_sel_arbiter
